calc_key_entry: RTL
===================

CALC_KEY_ENTRY -- requirements
Module: calc_key_entry

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle strobe; each high cycle is one key press
- key_code  input  4  0-9 digit; 0xA '+'; 0xB '-'; 0xC '='; 0xD clear; 0xE/0xF unused
- num1_en  input  1  downstream permission to start a new first operand
- num2_en  input  1  downstream permission to enter the second operand
- operand_a  output  16  first operand, 4 packed BCD digits, most significant digit in [15:12]
- operand_b  output  16  second operand, same format as operand_a
- digit_count  output  3  digits held in the operand currently being entered, range 0..4
- op_code  output  2  latched operation: 1 add, 2 sub, 3 equal, 0 none
- op_valid  output  1  one-cycle pulse when op_code is updated
- equal_valid  output  1  one-cycle pulse that accompanies op_code=3
- overflow  output  1  sticky flag: a digit was dropped because the operand was full
- state_dbg  output  2  current state, for debug only

Function
REQ-002 SHALL implement four states: ENTRY_A=0, OP_SENT=1, ENTRY_B=2, EQ_SENT=3.
REQ-003 Clear key (0xD) with key_valid SHALL have highest priority in every state:
- zero operand_a, operand_b, digit_count, op_code and overflow
- next state ENTRY_A
- no op_valid pulse
REQ-004 Codes 0xE and 0xF SHALL be ignored in all states.
REQ-005 ENTRY_A, digit key:
- if digit_count<4: operand_a <= {operand_a[11:0], key_code}; digit_count +1
- if digit_count=4: operand_a unchanged; overflow <= 1
REQ-006 ENTRY_A, '+' or '-' with digit_count>=1:
- op_code <= 1 or 2 respectively
- op_valid high for exactly the next cycle
- next state OP_SENT
REQ-007 ENTRY_A, '+' or '-' with digit_count=0, or '=' at any count: SHALL be ignored.
REQ-008 OP_SENT:
- all keys except clear ignored
- when num2_en=1: next state ENTRY_B; operand_b, digit_count and overflow zeroed
REQ-009 OP_SENT, key_valid in the same cycle as num2_en=1: state transition SHALL win and the key SHALL be dropped.
REQ-010 ENTRY_B, digit key: same rule as REQ-005, applied to operand_b.
REQ-011 ENTRY_B, '+' or '-': SHALL be ignored.
REQ-012 ENTRY_B, '=' with digit_count>=1:
- op_code <= 3
- op_valid and equal_valid high together for one cycle
- next state EQ_SENT
REQ-013 ENTRY_B, '=' with digit_count=0: SHALL be ignored.
REQ-014 EQ_SENT:
- operand_a, operand_b and op_code held stable for the downstream ALU
- keys other than clear ignored
- when num1_en=1: next state ENTRY_A; operand_a, operand_b, digit_count, op_code and overflow zeroed
REQ-015 op_valid and equal_valid SHALL never be high for two consecutive cycles.
REQ-016 Key-to-register latency SHALL be one cycle: the register update is visible the cycle after key_valid.
REQ-017 num1_en and num2_en SHALL be ignored outside EQ_SENT and OP_SENT respectively.

Reset
REQ-018 reset=1 at a rising clk edge SHALL force:
- state ENTRY_A
- all outputs 0, including pulses and overflow
- this overrides any concurrent key_valid
REQ-019 Reset asserted mid-operation, in any state, SHALL discard the partial operands with no op_valid pulse.

Verification
REQ-020 Keys 1,2,'+'; hold num2_en=1 for one cycle; keys 3,'=' -> expected responses:
- operand_a=0x0012
- op_valid with op_code=1
- operand_b=0x0003
- op_valid and equal_valid with op_code=3, state EQ_SENT
REQ-021 Keys 9,8,7,6,5 in ENTRY_A -> operand_a=0x9876, digit_count=4, overflow=1.
REQ-022 Keys '+' and '=' with digit_count=0 -> no op_valid; state stays ENTRY_A.
REQ-023 In OP_SENT, key 7 in the same cycle as num2_en=1 -> state ENTRY_B, operand_b=0x0000, digit_count=0.
REQ-024 In ENTRY_B with operand_b=0x0045, clear key -> all outputs 0, state ENTRY_A; a following num2_en has no effect.
REQ-025 In EQ_SENT, assert reset -> all outputs 0 next cycle; a later num1_en pulse causes no change.

Source files
------------

// File: rtl/calc_key_entry_if.sv
// Keypad-side and operand-side signals of the calculator key-entry block.
// master = key source / downstream observer, slave = calc_key_entry.
interface calc_key_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        num1_en;
  logic        num2_en;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  digit_count;
  logic [1:0]  op_code;
  logic        op_valid;
  logic        equal_valid;
  logic        overflow;
  logic [1:0]  state_dbg;

  modport master (
    output key_valid, key_code, num1_en, num2_en,
    input  operand_a, operand_b, digit_count, op_code,
           op_valid, equal_valid, overflow, state_dbg
  );

  modport slave (
    input  key_valid, key_code, num1_en, num2_en,
    output operand_a, operand_b, digit_count, op_code,
           op_valid, equal_valid, overflow, state_dbg
  );
endinterface

// File: rtl/calc_key_entry.sv
// Calculator key-entry sequencer: collects a BCD first operand, an operation,
// a BCD second operand and '=', then hands both operands to a downstream ALU.
module calc_key_entry (
  input  logic               clk,
  input  logic               reset,
  calc_key_entry_if.slave    kif
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    OP_SENT = 2'd1,
    ENTRY_B = 2'd2,
    EQ_SENT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_EQ   = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] operand_a_q, operand_a_d;
  logic [15:0] operand_b_q, operand_b_d;
  logic [2:0]  digit_count_q, digit_count_d;
  logic [1:0]  op_code_q, op_code_d;
  logic        op_valid_q, op_valid_d;
  logic        equal_valid_q, equal_valid_d;
  logic        overflow_q, overflow_d;

  logic key_digit;
  logic key_full;
  assign key_digit = (kif.key_code <= 4'd9);
  assign key_full  = (digit_count_q == 3'd4);

  // Next-state and register-update logic; pulses default low so they last one cycle.
  always_comb begin
    state_d       = state_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    digit_count_d = digit_count_q;
    op_code_d     = op_code_q;
    op_valid_d    = 1'b0;
    equal_valid_d = 1'b0;
    overflow_d    = overflow_q;

    if (kif.key_valid && kif.key_code == KEY_CLR) begin
      // Clear beats everything, including a concurrent num1_en/num2_en.
      state_d       = ENTRY_A;
      operand_a_d   = '0;
      operand_b_d   = '0;
      digit_count_d = '0;
      op_code_d     = OP_NONE;
      overflow_d    = 1'b0;
    end else begin
      unique case (state_q)
        ENTRY_A: begin
          if (kif.key_valid) begin
            if (key_digit) begin
              if (key_full) begin
                overflow_d = 1'b1;
              end else begin
                operand_a_d   = {operand_a_q[11:0], kif.key_code};
                digit_count_d = digit_count_q + 3'd1;
              end
            end else if ((kif.key_code == KEY_ADD || kif.key_code == KEY_SUB) &&
                         digit_count_q != 3'd0) begin
              op_code_d  = (kif.key_code == KEY_ADD) ? OP_ADD : OP_SUB;
              op_valid_d = 1'b1;
              state_d    = OP_SENT;
            end
          end
        end
        OP_SENT: begin
          // Keys are dropped here; only the downstream grant moves us on.
          if (kif.num2_en) begin
            state_d       = ENTRY_B;
            operand_b_d   = '0;
            digit_count_d = '0;
            overflow_d    = 1'b0;
          end
        end
        ENTRY_B: begin
          if (kif.key_valid) begin
            if (key_digit) begin
              if (key_full) begin
                overflow_d = 1'b1;
              end else begin
                operand_b_d   = {operand_b_q[11:0], kif.key_code};
                digit_count_d = digit_count_q + 3'd1;
              end
            end else if (kif.key_code == KEY_EQ && digit_count_q != 3'd0) begin
              op_code_d     = OP_EQ;
              op_valid_d    = 1'b1;
              equal_valid_d = 1'b1;
              state_d       = EQ_SENT;
            end
          end
        end
        EQ_SENT: begin
          // Operands stay frozen for the ALU until it asks for a new first operand.
          if (kif.num1_en) begin
            state_d       = ENTRY_A;
            operand_a_d   = '0;
            operand_b_d   = '0;
            digit_count_d = '0;
            op_code_d     = OP_NONE;
            overflow_d    = 1'b0;
          end
        end
        default: state_d = ENTRY_A;
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ENTRY_A;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      digit_count_q <= '0;
      op_code_q     <= OP_NONE;
      op_valid_q    <= 1'b0;
      equal_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      digit_count_q <= digit_count_d;
      op_code_q     <= op_code_d;
      op_valid_q    <= op_valid_d;
      equal_valid_q <= equal_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign kif.operand_a   = operand_a_q;
  assign kif.operand_b   = operand_b_q;
  assign kif.digit_count = digit_count_q;
  assign kif.op_code     = op_code_q;
  assign kif.op_valid    = op_valid_q;
  assign kif.equal_valid = equal_valid_q;
  assign kif.overflow    = overflow_q;
  assign kif.state_dbg   = state_q;

endmodule
